stopwatch_bcd: RTL
==================

Name: stopwatch_bcd

Overview:
- Downstream consumer of the slow divided clock (≈1 Hz toggle) produced by the clock divider.
- Synchronises that slow level into the fast system clock domain and turns each transition into a one-cycle "second" tick.
- Counts elapsed time as four BCD digits (MM:SS) under start/stop/clear control, for LED or 7-segment display logic further downstream.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on slow_clk; legal range 2..4.
- MAX_MIN, 59, highest minute value before wrap; binary integer, legal range 1..99.
- ALARM_MM, 1, alarm minute compare value in binary; used only with the optional feature.
- ALARM_SS, 30, alarm second compare value in binary (0..59); used only with the optional feature.

Ports:
- clock_in  input  1  system clock (100 MHz); sole clock.
- reset  input  1  asynchronous, active-high reset.
- slow_clk  input  1  divided clock from the divider; asynchronous to clock_in for design purposes.
- start_stop  input  1  debounced, clock_in-synchronous level; a rising edge toggles run/pause.
- clear  input  1  clock_in-synchronous level; zeroes the count and returns to IDLE.
- sec_ones  output  4  BCD seconds units, 0..9.
- sec_tens  output  4  BCD seconds tens, 0..5.
- min_ones  output  4  BCD minutes units, 0..9.
- min_tens  output  4  BCD minutes tens, 0..9.
- running  output  1  high while in RUN.
- rollover  output  1  one-cycle pulse on wrap from MAX_MIN:59 to 00:00.
- alarm_hit  output  1  alarm match flag; tied 0 without the optional feature.

Behaviour:
- Interface: one clock, clock_in. Reset is asynchronous and active-high, named reset. It clears every flop immediately, independent of clock_in.
- Reset values: all digits 0, running 0, rollover 0, alarm_hit 0, state IDLE, synchroniser and edge-detect flops 0, start_stop history flop 0.
- Tick generation:
  - slow_clk passes through SYNC_STAGES flops.
  - tick = synchronised value XOR its one-cycle-delayed copy.
  - Every slow_clk transition, rising or falling, is one elapsed second.
  - Latency: a slow_clk change is reflected in the digits on the (SYNC_STAGES+2)th clock_in rising edge after the change is sampled.
- start_stop edge: start_stop AND NOT its registered previous value. A level held high produces only one edge.
- States:
  - IDLE: count 00:00.
  - RUN: counts ticks.
  - PAUSE: holds count.
- Transitions:
  - IDLE to RUN on start edge.
  - RUN to PAUSE on start edge.
  - PAUSE to RUN on start edge.
  - clear from any state to IDLE; digits become 0 on the same edge.
- Priority and simultaneous events:
  - clear beats start edge; a start edge coinciding with clear is discarded.
  - Tick in RUN coinciding with a start edge: the increment is applied and the state moves to PAUSE.
  - Tick in PAUSE or IDLE coinciding with a start edge is ignored; the action is decided on the state at the start of the cycle.
  - Ticks outside RUN are dropped, never queued.
- Increment rules (BCD, no binary intermediate):
  - sec_ones 9 to 0 with carry into sec_tens.
  - sec_tens 5 to 0 with carry into minutes.
  - min_ones 9 to 0 with carry into min_tens.
- Wrap: when the minutes equal MAX_MIN and the seconds equal 59, the next tick sets all digits to 0. rollover pulses high for exactly that cycle, coincident with the digits showing 00:00. State stays RUN.
- Registering: all outputs are registered. running equals (state == RUN) and is updated on the same edge as the state.
- Reset mid-count: immediate return to reset values. A tick in flight is lost. The first tick after reset release is ignored because the state is IDLE.

Optional Feature:
- Macro STOPWATCH_ALARM_EN.
- Defined:
  - alarm_hit is registered high while state is RUN or PAUSE and the digits equal ALARM_MM:ALARM_SS, converted to BCD at elaboration.
  - It goes low on the edge where the count changes, on clear, or on reset.
- Undefined: alarm_hit is constant 0 and no compare logic is built.

Test Plan:
- Reset asserted mid-cycle with slow_clk=1 -> all outputs 0 immediately. After release, 3 slow_clk toggles with no start -> digits stay 00:00, running 0.
- start_stop pulse, then 10 slow_clk toggles -> running 1, digits read 00:10 (sec_tens=1, sec_ones=0). Each update lands 4 clock_in edges after the toggle with SYNC_STAGES=2.
- Count to 00:59, one more toggle -> 01:00. With MAX_MIN=1, from 01:59 one toggle -> 00:00 and rollover high for exactly 1 cycle.
- In RUN at 00:05, start_stop rises in the same cycle as a tick -> digits 00:06 and state PAUSE. 5 further toggles -> still 00:06. Start edge, then 1 toggle -> 00:07.
- At 00:07, clear and start_stop rise together -> digits 00:00, running 0, state IDLE. Start_stop held high for 100 cycles -> exactly one transition.
- STOPWATCH_ALARM_EN defined, ALARM_MM=0, ALARM_SS=3 -> alarm_hit rises on the edge showing 00:03 and falls on the edge showing 00:04. Macro undefined -> alarm_hit stays 0 throughout.

Source files
------------

// File: rtl/stopwatch_bcd.sv
// -----------------------------------------------------------------------------
// stopwatch_bcd
//   MM:SS BCD stopwatch clocked by clock_in. Every transition of the slow
//   divided clock (slow_clk) is synchronised, turned into a one-cycle tick and
//   counted as one elapsed second while the stopwatch is running.
//   start_stop rising edges toggle run/pause, clear returns to IDLE at 00:00.
//
//   Optional feature: define STOPWATCH_ALARM_EN to build the alarm compare
//   (alarm_hit high while RUN/PAUSE and the count equals ALARM_MM:ALARM_SS).
//   Without the macro alarm_hit is tied low and no compare logic exists.
// -----------------------------------------------------------------------------
module stopwatch_bcd #(
    parameter int SYNC_STAGES = 2,   // synchroniser depth on slow_clk, 2..4
    parameter int MAX_MIN     = 59,  // highest minute before wrap, 1..99
    parameter int ALARM_MM    = 1,   // alarm minutes (binary)
    parameter int ALARM_SS    = 30   // alarm seconds (binary), 0..59
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       slow_clk,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic       alarm_hit
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] min_tens;
        logic [3:0] min_ones;
        logic [3:0] sec_tens;
        logic [3:0] sec_ones;
    } bcd_time_t;

    // Wrap point split into BCD digits once, at elaboration.
    localparam logic [3:0] MAX_TENS = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_ONES = 4'(MAX_MIN % 10);

    // Parameter sanity checks, evaluated at elaboration only.
    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
            $error("stopwatch_bcd: SYNC_STAGES must be 2..4");
        end
        if (MAX_MIN < 1 || MAX_MIN > 99) begin : g_bad_max
            $error("stopwatch_bcd: MAX_MIN must be 1..99");
        end
        if (ALARM_MM < 0 || ALARM_MM > 99 || ALARM_SS < 0 || ALARM_SS > 59) begin : g_bad_alarm
            $error("stopwatch_bcd: alarm time out of range");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_dly_q;
    logic                   tick_q;
    logic                   start_prev_q;
    logic                   start_edge;
    logic                   advance;
    logic                   wrap;
    state_t                 state_q;
    bcd_time_t              count_q;
    bcd_time_t              count_inc;
    bcd_time_t              count_d;
    logic                   running_q;
    logic                   rollover_q;

    // Synchronise slow_clk, register the edge-detected tick and start_stop history.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            sync_q       <= '0;
            sync_dly_q   <= 1'b0;
            tick_q       <= 1'b0;
            start_prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the pre-edge
            // value of its neighbour, which is what makes this a shift chain.
            sync_q       <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            sync_dly_q   <= sync_q[SYNC_STAGES-1];
            tick_q       <= sync_q[SYNC_STAGES-1] ^ sync_dly_q;
            start_prev_q <= start_stop;
        end
    end

    assign start_edge = start_stop & ~start_prev_q;

    // A tick only advances the count in RUN, and clear overrides everything.
    assign advance = ~clear & (state_q == ST_RUN) & tick_q;

    // BCD increment of the current count, digit by digit with carries.
    always_comb begin
        // NOTE: defaults first so every path assigns every bit -- no latches.
        count_inc = count_q;
        wrap      = 1'b0;
        if (count_q.sec_ones != 4'd9) begin
            count_inc.sec_ones = count_q.sec_ones + 4'd1;
        end else begin
            count_inc.sec_ones = 4'd0;
            if (count_q.sec_tens != 4'd5) begin
                count_inc.sec_tens = count_q.sec_tens + 4'd1;
            end else begin
                count_inc.sec_tens = 4'd0;
                if (count_q.min_tens == MAX_TENS && count_q.min_ones == MAX_ONES) begin
                    wrap      = 1'b1;
                    count_inc = '0;
                end else if (count_q.min_ones != 4'd9) begin
                    count_inc.min_ones = count_q.min_ones + 4'd1;
                end else begin
                    count_inc.min_ones = 4'd0;
                    count_inc.min_tens = count_q.min_tens + 4'd1;
                end
            end
        end
    end

    // Next count value: clear zeroes, a tick in RUN increments, otherwise hold.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (advance) begin
            count_d = count_inc;
        end
    end

    // Control FSM with registered count, running and rollover outputs.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rollover_q <= advance & wrap;
            if (clear) begin
                state_q   <= ST_IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_edge) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (start_edge) begin
                            state_q   <= ST_PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    ST_PAUSE: begin
                        if (start_edge) begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef STOPWATCH_ALARM_EN
    localparam bcd_time_t ALARM_BCD = '{
        min_tens: 4'(ALARM_MM / 10),
        min_ones: 4'(ALARM_MM % 10),
        sec_tens: 4'(ALARM_SS / 10),
        sec_ones: 4'(ALARM_SS % 10)
    };

    logic active_d;
    logic alarm_q;

    // Stopwatch is in RUN or PAUSE after this edge.
    assign active_d = ~clear & ((state_q == ST_RUN) || (state_q == ST_PAUSE) ||
                                ((state_q == ST_IDLE) && start_edge));

    // Alarm flag tracks the count being loaded, so it changes on the same edge.
    always_ff @(posedge clock_in or posedge reset) begin
        if (reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= active_d && (count_d == ALARM_BCD);
        end
    end

    assign alarm_hit = alarm_q;
`else
    assign alarm_hit = 1'b0;
`endif

    assign sec_ones = count_q.sec_ones;
    assign sec_tens = count_q.sec_tens;
    assign min_ones = count_q.min_ones;
    assign min_tens = count_q.min_tens;
    assign running  = running_q;
    assign rollover = rollover_q;

endmodule
